// File: rtl/bmp_fb_loader.sv
// Purpose : parses a 24-bpp BMP byte stream and writes its pixels into a framebuffer.
// Latency : one framebuffer write, registered, the cycle after each pixel's R byte is accepted.
// Backpr. : none; a byte is consumed only when outen && file_found, and idle gaps are timed out.
// Ports   : clk/rstn (sync active-low); start, file_found, outen, outbyte = stream input;
//           fb_we/fb_addr/fb_wdata = framebuffer write port; busy/done/status/err_code = progress.
module bmp_fb_loader #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int ADDR_WIDTH     = 19,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  file_found,
  input  logic                  outen,
  input  logic [7:0]            outbyte,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic [23:0]           fb_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            status,
  output logic [2:0]            err_code
);

  // Rows in a BMP are padded to a multiple of 4 bytes.
  localparam int         PAD_BYTES = (4 - (3 * H_ACTIVE) % 4) % 4;
  localparam logic [1:0] PAD_LAST  = 2'(PAD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_HDR, S_SKIP, S_PIX, S_PAD, S_DONE, S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             byte_cnt_q, idle_q;
  logic [7:0]              sig0_q, sig1_q, b_q, g_q;
  logic [31:0]             offset_q, width_q, height_q;
  logic [15:0]             bpp_q, col_q, row_q;
  logic [1:0]              phase_q, pad_q;
  logic                    fb_we_q, busy_q, done_q;
  logic [ADDR_WIDTH-1:0]   fb_addr_q;
  logic [23:0]             fb_wdata_q;
  logic [3:0]              status_q;
  logic [2:0]              err_code_q;

  logic                    accept, loading, last_col, last_pix;
  logic [31:0]             height_abs, disp_row;
  logic [ADDR_WIDTH-1:0]   pix_addr;
  logic [2:0]              hdr_err, err_d;

  assign accept = outen & file_found;

  always_comb begin
    loading    = (state_q == S_HDR) || (state_q == S_SKIP) ||
                 (state_q == S_PIX) || (state_q == S_PAD);
    last_col   = (col_q == 16'(H_ACTIVE - 1));
    last_pix   = last_col && (row_q == 16'(V_ACTIVE - 1));
    height_abs = height_q[31] ? (~height_q + 32'd1) : height_q;
    // Positive height means the file stores the bottom row first.
    disp_row   = height_q[31] ? {16'd0, row_q} : (32'(V_ACTIVE - 1) - {16'd0, row_q});
    pix_addr   = ADDR_WIDTH'(disp_row * 32'(H_ACTIVE) + {16'd0, col_q});

    if ({sig0_q, sig1_q} != 16'h424D)                                   hdr_err = 3'd1;
    else if (width_q != 32'(H_ACTIVE) || height_abs != 32'(V_ACTIVE))   hdr_err = 3'd2;
    else if (bpp_q != 16'd24)                                           hdr_err = 3'd3;
    else if (offset_q < 32'd54)                                         hdr_err = 3'd4;
    else                                                                hdr_err = 3'd0;

    state_d = state_q;
    err_d   = 3'd0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_WAIT;
      S_WAIT: if (file_found) state_d = S_HDR;
      S_HDR: begin
        // Byte 53 is the last header byte; all checked fields are captured by then.
        if (accept && byte_cnt_q == 32'd53) begin
          err_d = hdr_err;
          if (hdr_err != 3'd0)            state_d = S_ERR;
          else if (offset_q == 32'd54)    state_d = S_PIX;
          else                            state_d = S_SKIP;
        end
      end
      S_SKIP: if (accept && (byte_cnt_q + 32'd1) == offset_q) state_d = S_PIX;
      S_PIX: begin
        if (accept && phase_q == 2'd2) begin
          if (last_pix)                          state_d = S_DONE;
          else if (last_col && PAD_BYTES != 0)   state_d = S_PAD;
        end
      end
      S_PAD: if (accept && pad_q == PAD_LAST) state_d = S_PIX;
      default: state_d = S_IDLE;
    endcase

    if (loading && !accept && idle_q == 32'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_ERR;
      err_d   = 3'd5;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      idle_q     <= '0;
      sig0_q     <= '0;
      sig1_q     <= '0;
      offset_q   <= '0;
      width_q    <= '0;
      height_q   <= '0;
      bpp_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      phase_q    <= '0;
      pad_q      <= '0;
      b_q        <= '0;
      g_q        <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= 4'h0;
      err_code_q <= 3'd0;
    end else begin
      state_q <= state_d;
      fb_we_q <= 1'b0;
      busy_q  <= (state_d == S_WAIT) || (state_d == S_HDR) || (state_d == S_SKIP) ||
                 (state_d == S_PIX)  || (state_d == S_PAD);
      done_q  <= (state_d == S_DONE);
      case (state_d)
        S_WAIT:                      status_q <= 4'h2;
        S_HDR, S_SKIP, S_PIX, S_PAD: status_q <= 4'h3;
        S_DONE:                      status_q <= 4'h4;
        S_ERR:                       status_q <= 4'hE;
        default:                     status_q <= 4'h0;
      endcase

      if (state_d == S_ERR && state_q != S_ERR) err_code_q <= err_d;

      // Arming a new load: clear error and all stream bookkeeping.
      if (state_d == S_WAIT && state_q != S_WAIT) begin
        err_code_q <= 3'd0;
        byte_cnt_q <= '0;
        idle_q     <= '0;
        col_q      <= '0;
        row_q      <= '0;
        phase_q    <= '0;
        pad_q      <= '0;
      end

      if (loading) begin
        if (accept) begin
          byte_cnt_q <= byte_cnt_q + 32'd1;
          idle_q     <= '0;
        end else begin
          idle_q     <= idle_q + 32'd1;
        end
      end

      if (accept && state_q == S_HDR) begin
        case (byte_cnt_q)
          32'd0:  sig0_q          <= outbyte;
          32'd1:  sig1_q          <= outbyte;
          32'd10: offset_q[7:0]   <= outbyte;
          32'd11: offset_q[15:8]  <= outbyte;
          32'd12: offset_q[23:16] <= outbyte;
          32'd13: offset_q[31:24] <= outbyte;
          32'd18: width_q[7:0]    <= outbyte;
          32'd19: width_q[15:8]   <= outbyte;
          32'd20: width_q[23:16]  <= outbyte;
          32'd21: width_q[31:24]  <= outbyte;
          32'd22: height_q[7:0]   <= outbyte;
          32'd23: height_q[15:8]  <= outbyte;
          32'd24: height_q[23:16] <= outbyte;
          32'd25: height_q[31:24] <= outbyte;
          32'd28: bpp_q[7:0]      <= outbyte;
          32'd29: bpp_q[15:8]     <= outbyte;
          default: ;
        endcase
      end

      // Pixel bytes arrive B, G, R; the R byte completes the write.
      if (accept && state_q == S_PIX) begin
        case (phase_q)
          2'd0: begin
            b_q     <= outbyte;
            phase_q <= 2'd1;
          end
          2'd1: begin
            g_q     <= outbyte;
            phase_q <= 2'd2;
          end
          default: begin
            fb_we_q    <= 1'b1;
            fb_wdata_q <= {outbyte, g_q, b_q};
            fb_addr_q  <= pix_addr;
            phase_q    <= 2'd0;
            if (last_col) begin
              col_q <= '0;
              row_q <= row_q + 16'd1;
            end else begin
              col_q <= col_q + 16'd1;
            end
          end
        endcase
      end

      if (accept && state_q == S_PAD) pad_q <= (pad_q == PAD_LAST) ? 2'd0 : pad_q + 2'd1;
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign status   = status_q;
  assign err_code = err_code_q;

endmodule

// File: doc/bmp_fb_loader.md
BMP_FB_LOADER -- requirements
Module: bmp_fb_loader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: required image width in pixels.
REQ-002 SHALL have parameter V_ACTIVE, default 480: required image height in pixels.
REQ-003 SHALL have parameter ADDR_WIDTH, default 19: framebuffer address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000: maximum idle gap between stream bytes while loading.
REQ-005 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-006 SHALL have port rstn, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle pulse that arms a load.
REQ-008 SHALL have port file_found, input, 1 bit: SD file reader located the file.
REQ-009 SHALL have port outen, input, 1 bit: outbyte valid this cycle.
REQ-010 SHALL have port outbyte, input, 8 bits: file byte stream in file order.
REQ-011 SHALL have port fb_we, output, 1 bit: framebuffer write strobe.
REQ-012 SHALL have port fb_addr, output, ADDR_WIDTH bits: framebuffer write address, row*H_ACTIVE+col.
REQ-013 SHALL have port fb_wdata, output, 24 bits: pixel {R,G,B}.
REQ-014 SHALL have port busy, output, 1 bit: load in progress.
REQ-015 SHALL have port done, output, 1 bit: full frame written; held until next start or reset.
REQ-016 SHALL have port status, output, 4 bits: 0 idle, 2 file found, 3 loading, 4 display, E error.
REQ-017 SHALL have port err_code, output, 3 bits: 0 none, 1 bad signature, 2 bad size, 3 bad bpp, 4 bad offset, 5 timeout.

Function
REQ-018 SHALL implement states IDLE, WAIT_FILE, HEADER, SKIP, PIXEL, PAD, DONE, ERR.
REQ-019 SHALL leave IDLE on start, clear done/err_code and the byte counter, and enter WAIT_FILE.
REQ-020 SHALL move WAIT_FILE->HEADER when file_found=1; status=2.
REQ-021 SHALL accept a byte only on cycles with outen=1 and file_found=1; other cycles consume nothing.
REQ-022 SHALL count accepted bytes in a 32-bit byte counter starting at 0.
REQ-023 SHALL capture in HEADER: bytes 0-1 signature, 10-13 data offset, 18-21 width, 22-25 signed height, 28-29 bpp; all multi-byte fields little-endian.
REQ-024 SHALL check fields on accepting byte 53 with priority signature(0x42,0x4D)->1, width!=H_ACTIVE or |height|!=V_ACTIVE->2, bpp!=24->3, offset<54->4; any failure enters ERR.
REQ-025 SHALL enter SKIP after a passing check, discarding bytes until the counter equals offset, then enter PIXEL; offset==54 goes directly to PIXEL.
REQ-026 SHALL assemble each pixel from 3 bytes in order B, G, R.
REQ-027 SHALL assert fb_we for exactly one cycle, the cycle after the R byte is accepted, with fb_wdata={R,G,B}.
REQ-028 SHALL map rows for positive height as bottom-up (file row r -> display row V_ACTIVE-1-r) and for negative height as top-down (file row r -> row r).
REQ-029 SHALL, after each row's H_ACTIVE pixels, discard (4-(3*H_ACTIVE)%4)%4 padding bytes in PAD; zero padding skips PAD.
REQ-030 SHALL enter DONE on the fb_we of the last pixel, assert done=1 and status=4, and ignore any further bytes.
REQ-031 SHALL drive status=3 and busy=1 in HEADER, SKIP, PIXEL and PAD, and busy=1 in WAIT_FILE.
REQ-032 SHALL count cycles without an accepted byte in HEADER/SKIP/PIXEL/PAD and enter ERR with err_code=5 on reaching TIMEOUT_CYCLES; the count clears on every accepted byte.
REQ-033 SHALL, in ERR, hold status=E and err_code, drive busy=0, and leave ERR only on start or reset.
REQ-034 SHALL ignore start while busy=1.
REQ-035 SHALL treat file_found falling in HEADER..PAD as a stall subject to timeout, not as an error.

Reset
REQ-036 SHALL, with rstn=0 at a clk edge, enter IDLE, clear counters, and drive fb_we=0, fb_addr=0, fb_wdata=0, busy=0, done=0, status=0, err_code=0, including mid-load.

Verification
REQ-037 SHALL pass this case: valid 640x480 24bpp bottom-up stream with offset 54 -> first fb_we has fb_addr=306560 (479*640); last has fb_addr=639; 307200 strobes; done=1, status=4.
REQ-038 SHALL pass this case: same stream with height=-480 -> first fb_addr=0, last fb_addr=307199.
REQ-039 SHALL pass this case: offset=122 -> 68 bytes skipped, and the first pixel equals bytes 122-124 as {R,G,B}={b124,b123,b122}.
REQ-040 SHALL pass this case: signature 0x42,0x41 -> ERR with err_code=1 and no fb_we; a bad-bpp stream (bpp=32) -> err_code=3.
REQ-041 SHALL pass this case: outen stops after byte 1000 with TIMEOUT_CYCLES=100 -> ERR with err_code=5 exactly 100 cycles later.
REQ-042 SHALL pass this case: rstn=0 during PIXEL -> IDLE with all outputs zero on the next edge; a later start with a fresh stream loads correctly.
